// File: rtl/apb_ahb_bridge.sv
// APB4 completer to AHB-Lite manager: each APB transfer becomes one AHB SINGLE transfer.
// Zero-wait latency setup->PREADY is 3 cycles; an illegal write strobe answers in 1 cycle.
module apb_ahb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [3:0]            PSTRB,
  input  logic [2:0]            PPROT,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [DATA_WIDTH-1:0] HRDATA
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [2:0] SIZE_BYTE    = 3'b000;
  localparam logic [2:0] SIZE_HALF    = 3'b001;
  localparam logic [2:0] SIZE_WORD    = 3'b010;

  state_t                state;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  strb_ok;
  logic [2:0]            strb_size;
  logic [1:0]            strb_off;

  // PPROT[1] (secure/non-secure) has no AHB-Lite counterpart
  wire unused_pprot = PPROT[1];

  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;

  // Only naturally aligned byte, halfword and word lanes map onto one AHB beat.
  always_comb begin
    strb_ok   = 1'b1;
    strb_size = SIZE_WORD;
    strb_off  = 2'b00;
    case (PSTRB)
      4'b1111: begin strb_size = SIZE_WORD; strb_off = 2'b00; end
      4'b0011: begin strb_size = SIZE_HALF; strb_off = 2'b00; end
      4'b1100: begin strb_size = SIZE_HALF; strb_off = 2'b10; end
      4'b0001: begin strb_size = SIZE_BYTE; strb_off = 2'b00; end
      4'b0010: begin strb_size = SIZE_BYTE; strb_off = 2'b01; end
      4'b0100: begin strb_size = SIZE_BYTE; strb_off = 2'b10; end
      4'b1000: begin strb_size = SIZE_BYTE; strb_off = 2'b11; end
      default: strb_ok = 1'b0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      HTRANS  <= TRANS_IDLE;
      HADDR   <= '0;
      HWRITE  <= 1'b0;
      HSIZE   <= 3'b000;
      HPROT   <= 4'b0000;
      HWDATA  <= '0;
      wdata_q <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (PSEL && !PENABLE) begin
            if (PWRITE && !strb_ok) begin
              state   <= S_RESP;
              PREADY  <= 1'b1;
              PSLVERR <= 1'b1;
              PRDATA  <= '0;
            end else begin
              state   <= S_ADDR;
              HTRANS  <= TRANS_NONSEQ;
              HADDR   <= {PADDR[ADDR_WIDTH-1:2], (PWRITE ? strb_off : 2'b00)};
              HWRITE  <= PWRITE;
              HSIZE   <= PWRITE ? strb_size : SIZE_WORD;
              HPROT   <= {2'b00, PPROT[0], ~PPROT[2]};
              wdata_q <= PWDATA;
            end
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            state  <= S_DATA;
            HTRANS <= TRANS_IDLE;
            HWDATA <= wdata_q;
          end
        end
        S_DATA: begin
          // The first ERROR cycle arrives with HREADY low and is simply waited out.
          if (HREADY) begin
            state   <= S_RESP;
            PREADY  <= 1'b1;
            PSLVERR <= HRESP;
            PRDATA  <= (!HWRITE && !HRESP) ? HRDATA : '0;
          end
        end
        S_RESP: begin
          state   <= S_IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
